// File: rtl/int_to_fp_seq_pkg.sv
// Shared constants and state encoding for the integer-to-float converter.
package int_to_fp_seq_pkg;

  localparam int INT_W  = 16;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
  localparam int MAG_W  = INT_W - 1;

  // Saturation result used for the one operand whose magnitude does not fit.
  localparam logic [EXP_W-1:0]  EXP_MAX  = 4'd15;
  localparam logic [FRAC_W-1:0] FRAC_MAX = 8'hFF;
  localparam logic [INT_W-1:0]  INT_MIN  = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/int_to_fp_seq.sv
// Sequential 16-bit two's-complement integer to 13-bit float converter.
// Normalisation shifts the magnitude left one bit per clock until its
// top bit is set; the remaining low bits are truncated.
//
// Handshake: start is sampled only while ready = 1. ready drops the cycle
// after acceptance and returns the cycle after done_tick. done_tick is a
// one-cycle pulse, and sign/exp/frac/ovf are valid with it and hold until
// the next done_tick.
module int_to_fp_seq
  import int_to_fp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [INT_W-1:0]  int_in,
  output logic              ready,
  output logic              done_tick,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic              ovf
);

  state_t           state;
  logic [MAG_W-1:0] r;
  logic [EXP_W-1:0] e;
  logic             s;
  logic [INT_W-1:0] neg;
  logic [MAG_W-1:0] mag;

  // Absolute value of the operand; -32768 is handled separately.
  always_comb begin
    neg = '0;
    mag = '0;
    neg = INT_W'(0) - int_in;
    mag = int_in[INT_W-1] ? neg[MAG_W-1:0] : int_in[MAG_W-1:0];
  end

  // Control FSM plus shift/exponent datapath; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      sign      <= 1'b0;
      exp       <= '0;
      frac      <= '0;
      ovf       <= 1'b0;
      r         <= '0;
      e         <= '0;
      s         <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s     <= int_in[INT_W-1];
            ready <= 1'b0;
            if (int_in == '0) begin
              sign      <= 1'b0;
              exp       <= '0;
              frac      <= '0;
              ovf       <= 1'b0;
              done_tick <= 1'b1;
              state     <= DONE;
            end else if (int_in == INT_MIN) begin
              sign      <= 1'b1;
              exp       <= EXP_MAX;
              frac      <= FRAC_MAX;
              ovf       <= 1'b1;
              done_tick <= 1'b1;
              state     <= DONE;
            end else begin
              r     <= mag;
              e     <= EXP_MAX;
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (r[MAG_W-1]) begin
            sign      <= s;
            exp       <= e;
            frac      <= r[MAG_W-1 -: FRAC_W];
            ovf       <= 1'b0;
            done_tick <= 1'b1;
            state     <= DONE;
          end else begin
            // A nonzero magnitude reaches bit 14 before e reaches 0.
            r <= {r[MAG_W-2:0], 1'b0};
            e <= e - 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Self-checking bench for int_to_fp_seq: directed cases, random operands,
// back-to-back operation, ignored starts and an aborting reset.
module tb_int_to_fp_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] int_in;
  logic        ready;
  logic        done_tick;
  logic        sign;
  logic [3:0]  exp;
  logic [7:0]  frac;
  logic        ovf;

  int checks;
  int failures;

  // Scoreboard: expected {sign, exp, frac, ovf} and latency per conversion.
  logic [13:0] exp_q[$];
  int          lat_q[$];

  int_to_fp_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .int_in    (int_in),
    .ready     (ready),
    .done_tick (done_tick),
    .sign      (sign),
    .exp       (exp),
    .frac      (frac),
    .ovf       (ovf)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: value = 0.frac * 2^exp, frac holds the top 8 significant bits.
  function automatic logic [13:0] model(input logic [15:0] v, output int lat);
    int a;
    int nbits;
    int fr;
    int sv;
    sv = int'($signed(v));
    if (sv == 0) begin
      lat = 1;
      return 14'd0;
    end
    if (sv == -32768) begin
      lat = 1;
      return {1'b1, 4'd15, 8'hFF, 1'b1};
    end
    a = (sv < 0) ? -sv : sv;
    nbits = 0;
    while ((1 << nbits) <= a) nbits++;
    fr = (a * 256) >> nbits;
    lat = 17 - nbits;
    return {sv < 0, 4'(nbits), 8'(fr), 1'b0};
  endfunction

  // Driver: called at a negedge with ready high; returns at the negedge
  // of the cycle after done_tick, so back-to-back calls start at N + L + 1.
  task automatic convert(input logic [15:0] v, input bit noise);
    int lat;
    int k;
    logic [13:0] expv;
    int exp_lat;
    expv = model(v, lat);
    exp_q.push_back(expv);
    lat_q.push_back(lat);
    check("ready_before_start", 32'(ready), 32'd1);
    start  = 1'b1;
    int_in = v;
    @(posedge clk);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k == 1) check("ready_falls", 32'(ready), 32'd0);
      if (done_tick) break;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        int_in = 16'($urandom);
      end
    end
    start = 1'b0;
    expv    = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    if (!done_tick) begin
      check("timeout", 32'(k), 32'(exp_lat));
    end else begin
      check("latency", 32'(k), 32'(exp_lat));
      check("result", 32'({sign, exp, frac, ovf}), 32'(expv));
    end
    @(negedge clk);
    check("ready_rises", 32'(ready), 32'd1);
    check("done_single", 32'(done_tick), 32'd0);
    check("result_hold", 32'({sign, exp, frac, ovf}), 32'(expv));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    int_in   = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_result", 32'({sign, exp, frac, ovf}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    convert(16'd5, 1'b0);
    convert(16'd300, 1'b0);
    convert(16'hFFFF, 1'b0);
    convert(16'd32767, 1'b1);
    convert(16'd0, 1'b1);
    convert(16'h8000, 1'b0);
    convert(16'd1, 1'b1);
    convert(16'd255, 1'b0);
    convert(16'hFF00, 1'b0);
    convert(16'h8001, 1'b0);

    // Random operands, each magnitude class exercised.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] v;
      v = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = 16'(0) - v;
      convert(v, 1'($urandom_range(0, 1)));
    end

    // Abort a conversion of 1 with reset while normalising.
    convert(16'd300, 1'b0);
    start  = 1'b1;
    int_in = 16'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done_tick), 32'd0);
    check("abort_result", 32'({sign, exp, frac, ovf}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done_tick), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("post_abort_idle", 32'({done_tick, ready}), 32'b01);
    end

    convert(16'd12, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_to_fp_seq.md
# int_to_fp_seq

Sequential converter from a 16-bit two's-complement integer to the 13-bit floating-point format used by the floating-point comparator and adder blocks. The format is sign + 4-bit unsigned exponent + 8-bit normalized fraction, with value = (−1)^sign × 0.frac × 2^exp and frac[7] = 1 for any nonzero value. It sits upstream of the comparator and adder, feeding them operands, and is the converse of the fp-to-integer path. Normalization is iterative, one left shift per clock, under a start/done handshake.

## Interface
- Parameters: none. All widths are fixed by the 13-bit format; constants come from the shared package.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a conversion; sampled only while ready = 1
- int_in  in  16  signed two's-complement operand; sampled in the start cycle
- ready  out  1  high in idle; the block accepts start only when this is high
- done_tick  out  1  one-cycle pulse; result outputs are valid in this cycle
- sign  out  1  result sign (registered)
- exp  out  4  result exponent (registered)
- frac  out  8  result fraction (registered)
- ovf  out  1  high with done_tick when int_in = −32768 (registered)

## Operation
- States: IDLE, NORM, DONE.
- IDLE:
  - ready = 1.
  - On start = 1, capture s = int_in[15] and mag = |int_in| (15 bits).
  - If int_in = 0: set result to sign 0, exp 0, frac 0, ovf 0, and go to DONE.
  - If int_in = −32768: set result to sign 1, exp 15, frac 8'hFF, ovf 1, and go to DONE.
  - Otherwise: r[14:0] ← mag, e ← 15, go to NORM.
  - start while not in IDLE is ignored.
- NORM:
  - If r[14] = 1: latch sign ← s, exp ← e, frac ← r[14:7], ovf ← 0, and go to DONE.
  - Else: r ← r << 1, e ← e − 1.
  - e never underflows, because a nonzero mag has r[14] set by the time e = 1.
- DONE:
  - done_tick = 1 for this one cycle; go to IDLE.
- Arithmetic rules:
  - Rounding is truncation: r[6:0] is discarded.
  - Negative zero is never produced.
  - The result is exact for |int_in| < 256.
- Outputs hold their last result until the next DONE. The internal r, e and s are not visible.
- Reset values (any state, any time): state IDLE, ready 1, done_tick 0, sign 0, exp 0, frac 0, ovf 0.
- Reset asserted mid-conversion aborts it: no done_tick and no output update. The first start after reset deasserts is accepted normally.

## Timing
- Let N be the cycle in which start is sampled high in IDLE, and p be the bit index of the leading one of mag.
- done_tick is high in cycle N + L:
  - L = 16 − p for a nonzero, non-overflow operand. Minimum L = 2 (p = 14); maximum L = 16 (p = 0).
  - L = 1 for zero and for −32768.
- sign, exp, frac and ovf change at the clock edge that enters DONE. They are valid together with done_tick.
- ready falls in cycle N + 1 and rises in cycle N + L + 1.
- Back-to-back operation: start may be asserted in cycle N + L + 1. Throughput is one conversion per L + 1 cycles.
- No combinational path from any input to any output.

## Structure
- Shared package holds:
  - INT_W = 16, EXP_W = 4, FRAC_W = 8
  - state encodings IDLE/NORM/DONE
  - saturation constants EXP_MAX = 15, FRAC_MAX = 8'hFF
- Single module: FSMD with a state register plus r/e/s datapath registers. No sub-module; the shift is a single-bit shift per cycle.

## Test plan
- int_in = 5 → sign 0, exp 3, frac 8'hA0, ovf 0; done_tick at N + 14.
- int_in = 300 → sign 0, exp 9, frac 8'h96 (truncated); done_tick at N + 8.
- int_in = −1 (16'hFFFF) → sign 1, exp 1, frac 8'h80; done_tick at N + 16.
- int_in = 32767, then 0 back-to-back with start at N + L + 1:
  - 32767 → sign 0, exp 15, frac 8'hFF, L = 2.
  - 0 → all result outputs 0, L = 1.
  - start pulses during NORM are ignored.
- int_in = −32768 → sign 1, exp 15, frac 8'hFF, ovf 1, L = 1.
- Reset pulse asserted in NORM while converting 1 → no done_tick; outputs read 0 and ready = 1 in the same cycle.
- Post-reset conversion of 12 → sign 0, exp 4, frac 8'hC0.
